axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 64: data width; strobe width is DW/8.
REQ-004 SHALL have parameter TMO, default 255: W-phase idle timeout in cycles.
REQ-005 SHALL have port axi_aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_awpld, input, NREQ*(AW+13): per requester {addr, len[7:0], size[2:0], burst[1:0]}.
REQ-008 SHALL have ports req_awvalid (input) and req_awready (output), each NREQ: per-requester AW handshake.
REQ-009 SHALL have port req_wpld, input, NREQ*(DW+DW/8+1): per requester {data, strb, last}.
REQ-010 SHALL have ports req_wvalid (input) and req_wready (output), each NREQ: per-requester W handshake.
REQ-011 SHALL have ports req_bvalid (output, NREQ), req_bresp (output, 2) and req_bready (input, NREQ): per-requester B channel.
REQ-012 SHALL have ports axi_awpld (output, AW+13), axi_awvalid (output, 1) and axi_awready (input, 1): shared AW channel.
REQ-013 SHALL have ports axi_wpld (output, DW+DW/8+1), axi_wvalid (output, 1) and axi_wready (input, 1): shared W channel.
REQ-014 SHALL have ports axi_bresp (input, 2), axi_bvalid (input, 1) and axi_bready (output, 1): shared B channel.
REQ-015 SHALL have ports grant (output, NREQ, one-hot or zero) and err_wlast (output, 1, sticky).

Function
REQ-016 SHALL run an FSM with states IDLE, AW, W and B, and keep at most one write in flight.
REQ-017 IDLE: when any req_awvalid is high, SHALL pick the winner by round-robin, register its AW payload to axi_awpld, set grant and axi_awvalid, and go to AW on the next cycle.
REQ-018 Round-robin SHALL search starting at the index after the last winner, so the last winner has lowest priority; after reset the search starts at index 0.
REQ-019 AW: SHALL hold axi_awvalid and axi_awpld stable until axi_awready is sampled high; in that cycle req_awready[grant] SHALL be 1 (combinational from axi_awready).
REQ-020 AW: on that handshake, SHALL load beat counter = len, deassert axi_awvalid and go to W.
REQ-021 W: SHALL pass through axi_wpld/axi_wvalid from the granted requester, route axi_wready to req_wready[grant] only, and hold all other req_wready low.
REQ-022 W: SHALL decrement the counter on each beat (wvalid and wready both high); the beat taken when the counter is 0 is the final beat and moves the FSM to B.
REQ-023 On each W beat, if the requester's last bit differs from (counter==0), SHALL set err_wlast=1 and leave the beat count unchanged (counter-driven).
REQ-024 The wlast bit driven on axi_wpld SHALL be (counter==0), not the requester's bit.
REQ-025 B: SHALL route axi_bvalid/axi_bresp to the granted requester and drive axi_bready = req_bready[grant]; on the B handshake, clear grant and go to IDLE.
REQ-026 Non-granted req_awready, req_wready and req_bvalid SHALL be 0 in every state.
REQ-027 A request arriving while the FSM is not in IDLE SHALL wait; back-to-back transactions SHALL have one IDLE cycle between the B handshake and the next axi_awvalid.
REQ-028 A request that deasserts in IDLE before being granted SHALL be ignored (no grant).

Reset
REQ-029 In any state, reset SHALL force the FSM to IDLE and the following to 0: grant, axi_awvalid, axi_bready, all req_*ready, req_bvalid, err_wlast and the beat counter; the round-robin pointer SHALL be set so index 0 has highest priority.
REQ-030 A transaction interrupted by reset SHALL be abandoned; no response is generated for it.

Configuration
REQ-031 With macro AXI_WR_ARB_TIMEOUT_EN defined, SHALL count consecutive W-state cycles with no beat; on reaching TMO, SHALL drive the remaining beats with strb=0 (wvalid forced high) to finish the burst, and flag the transaction with err_wlast.
REQ-032 Without AXI_WR_ARB_TIMEOUT_EN, there SHALL be no timeout counter and W SHALL wait indefinitely; TMO is then unused.

Structure
REQ-033 Package axi_arb_pkg SHALL hold the FSM state enum, the AW/W payload width functions and the field-offset constants.
REQ-034 Sub-module rr_arbiter SHALL implement the round-robin pick and pointer update as a combinational pick plus a registered pointer.

Verification
REQ-035 Single requester 1, len=3, axi_awready delayed 2 cycles: grant=4'b0010; 4 W beats; 4th beat wlast=1; req_bvalid[1] pulses; FSM back in IDLE.
REQ-036 All 4 requesters continuously valid, len=0: grant order is 0,1,2,3,0, with exactly one IDLE cycle between transactions.
REQ-037 Requester 2 with len=1 asserts last on beat 0: err_wlast=1 and 2 beats are still forwarded.
REQ-038 rst asserted during the W state: next cycle all outputs at reset values; a new request is granted starting from index 0.
REQ-039 With AXI_WR_ARB_TIMEOUT_EN and TMO=8, requester stalls after 1 of 4 beats: after 8 cycles 3 beats with strb=0 are sent, then B completes.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and payload layout for the AXI write arbiter.
// AW payload is {addr, len[7:0], size[2:0], burst[1:0]}; W payload is {data, strb, last}.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAw,
      StW,
      StB
   } arb_state_e;

   localparam int unsigned AwBurstLsb = 0;
   localparam int unsigned AwSizeLsb  = 2;
   localparam int unsigned AwLenLsb   = 5;
   localparam int unsigned AwAddrLsb  = 13;
   localparam int unsigned AwFieldsW  = 13;

   localparam int unsigned WLastBit = 0;
   localparam int unsigned WStrbLsb = 1;

   function automatic int unsigned aw_pld_w(input int unsigned aw);
      return aw + AwFieldsW;
   endfunction

   function automatic int unsigned w_pld_w(input int unsigned dw);
      return dw + dw / 8 + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over a request vector; the pointer names the highest-priority index
// and moves to one past the winner whenever a pick is consumed.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 update,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int unsigned IdxW = $clog2(N);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            found;
   int unsigned     k;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (int'(ptr_q) + i) % N;
         if (!found && req[k]) begin
            found   = 1'b1;
            gnt[k]  = 1'b1;
            gnt_idx = IdxW'(k);
         end
      end
      ptr_d = ptr_q;
      if (update && found) begin
         ptr_d = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI write arbiter, one write in flight, round-robin between requesters.
// Define AXI_WR_ARB_TIMEOUT_EN to flush a stalled W burst with strb=0 after TMO idle cycles.
module axi_wr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 64,
   parameter int unsigned TMO  = 255
) (
   input  logic                          axi_aclk,
   input  logic                          rst,
   input  logic [NREQ*aw_pld_w(AW)-1:0]  req_awpld,
   input  logic [NREQ-1:0]               req_awvalid,
   output logic [NREQ-1:0]               req_awready,
   input  logic [NREQ*w_pld_w(DW)-1:0]   req_wpld,
   input  logic [NREQ-1:0]               req_wvalid,
   output logic [NREQ-1:0]               req_wready,
   output logic [NREQ-1:0]               req_bvalid,
   output logic [1:0]                    req_bresp,
   input  logic [NREQ-1:0]               req_bready,
   output logic [aw_pld_w(AW)-1:0]       axi_awpld,
   output logic                          axi_awvalid,
   input  logic                          axi_awready,
   output logic [w_pld_w(DW)-1:0]        axi_wpld,
   output logic                          axi_wvalid,
   input  logic                          axi_wready,
   input  logic [1:0]                    axi_bresp,
   input  logic                          axi_bvalid,
   output logic                          axi_bready,
   output logic [NREQ-1:0]               grant,
   output logic                          err_wlast
);

   localparam int unsigned AwpW = aw_pld_w(AW);
   localparam int unsigned WpW  = w_pld_w(DW);
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned IdxW = $clog2(NREQ);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [AwpW-1:0] awpld_q, awpld_d;
   logic            awvalid_q, awvalid_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] rr_gnt;
   logic [IdxW-1:0] rr_idx;
   logic            rr_update;
   logic [WpW-1:0]  cur_w;
   logic            beat;
   logic            tmo_force;
   logic            tmo_err;

   assign rr_update = (state_q == StIdle) && (|req_awvalid);

   rr_arbiter #(
      .N(NREQ)
   ) u_rr (
      .clk    (axi_aclk),
      .rst    (rst),
      .req    (req_awvalid),
      .update (rr_update),
      .gnt    (rr_gnt),
      .gnt_idx(rr_idx)
   );

   assign axi_awpld   = awpld_q;
   assign axi_awvalid = awvalid_q;
   assign grant       = grant_q;
   assign err_wlast   = err_q;
   assign req_bresp   = axi_bresp;
   assign cur_w       = req_wpld[int'(idx_q)*WpW +: WpW];

   // Channel routing: only the granted index ever sees a handshake.
   always_comb begin
      req_awready = '0;
      req_wready  = '0;
      req_bvalid  = '0;
      axi_wvalid  = 1'b0;
      axi_wpld    = '0;
      axi_bready  = 1'b0;
      unique case (state_q)
         StAw: req_awready[idx_q] = axi_awready;
         StW: begin
            axi_wvalid        = req_wvalid[idx_q] | tmo_force;
            req_wready[idx_q] = axi_wready & ~tmo_force;
            axi_wpld          = {cur_w[WpW-1:1], cnt_q == 8'd0};
            if (tmo_force) begin
               axi_wpld[WStrbLsb +: SW] = '0;
            end
         end
         StB: begin
            req_bvalid[idx_q] = axi_bvalid;
            axi_bready        = req_bready[idx_q];
         end
         default: ;
      endcase
   end

   assign beat = (state_q == StW) && axi_wvalid && axi_wready;

`ifdef AXI_WR_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TMO + 1);

   logic [TmoW-1:0] idle_cnt_q, idle_cnt_d;
   logic            tmo_q, tmo_d;

   assign tmo_force = tmo_q;

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      tmo_d      = tmo_q;
      tmo_err    = 1'b0;
      if (state_q != StW) begin
         idle_cnt_d = '0;
         tmo_d      = 1'b0;
      end else if (beat) begin
         idle_cnt_d = '0;
      end else if (!tmo_q) begin
         if (idle_cnt_q == TmoW'(TMO - 1)) begin
            tmo_d   = 1'b1;
            tmo_err = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         idle_cnt_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         tmo_q      <= tmo_d;
      end
   end
`else
   assign tmo_force = 1'b0;
   assign tmo_err   = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      awpld_d   = awpld_q;
      awvalid_d = awvalid_q;
      cnt_d     = cnt_q;
      err_d     = err_q | tmo_err;
      unique case (state_q)
         StIdle: begin
            if (|req_awvalid) begin
               grant_d   = rr_gnt;
               idx_d     = rr_idx;
               awpld_d   = req_awpld[int'(rr_idx)*AwpW +: AwpW];
               awvalid_d = 1'b1;
               state_d   = StAw;
            end
         end
         StAw: begin
            if (axi_awready) begin
               awvalid_d = 1'b0;
               cnt_d     = awpld_q[AwLenLsb +: 8];
               state_d   = StW;
            end
         end
         StW: begin
            if (beat) begin
               // The counter owns burst length; a disagreeing last bit is only flagged.
               if (!tmo_force && (cur_w[WLastBit] != (cnt_q == 8'd0))) begin
                  err_d = 1'b1;
               end
               if (cnt_q == 8'd0) begin
                  state_d = StB;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         StB: begin
            if (axi_bvalid && req_bready[idx_q]) begin
               grant_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         idx_q     <= '0;
         awpld_q   <= '0;
         awvalid_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         awpld_q   <= awpld_d;
         awvalid_q <= awvalid_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (NREQ=4, AW=32, DW=64, TMO=8).
// The timeout scenario is built only when AXI_WR_ARB_TIMEOUT_EN is defined.
module tb_axi_wr_arbiter;

   logic         axi_aclk = 1'b0;
   logic         rst;
   logic [179:0] req_awpld;
   logic [3:0]   req_awvalid, req_awready;
   logic [291:0] req_wpld;
   logic [3:0]   req_wvalid, req_wready;
   logic [3:0]   req_bvalid;
   logic [1:0]   req_bresp;
   logic [3:0]   req_bready;
   logic [44:0]  axi_awpld;
   logic         axi_awvalid, axi_awready;
   logic [72:0]  axi_wpld;
   logic         axi_wvalid, axi_wready;
   logic [1:0]   axi_bresp;
   logic         axi_bvalid, axi_bready;
   logic [3:0]   grant;
   logic         err_wlast;

   int checks = 0;
   int errors = 0;

   always #5 axi_aclk = ~axi_aclk;

   axi_wr_arbiter #(
      .NREQ(4),
      .AW  (32),
      .DW  (64),
      .TMO (8)
   ) dut (
      .axi_aclk   (axi_aclk),
      .rst        (rst),
      .req_awpld  (req_awpld),
      .req_awvalid(req_awvalid),
      .req_awready(req_awready),
      .req_wpld   (req_wpld),
      .req_wvalid (req_wvalid),
      .req_wready (req_wready),
      .req_bvalid (req_bvalid),
      .req_bresp  (req_bresp),
      .req_bready (req_bready),
      .axi_awpld  (axi_awpld),
      .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready),
      .axi_wpld   (axi_wpld),
      .axi_wvalid (axi_wvalid),
      .axi_wready (axi_wready),
      .axi_bresp  (axi_bresp),
      .axi_bvalid (axi_bvalid),
      .axi_bready (axi_bready),
      .grant      (grant),
      .err_wlast  (err_wlast)
   );

   task automatic tick();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic clear_inputs();
      req_awpld   = '0;
      req_awvalid = '0;
      req_wpld    = '0;
      req_wvalid  = '0;
      req_bready  = '0;
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      axi_bresp   = 2'b00;
      axi_bvalid  = 1'b0;
   endtask

   function automatic logic [44:0] aw_word(input logic [31:0] addr, input logic [7:0] len);
      return {addr, len, 3'd3, 2'b01};
   endfunction

   task automatic set_aw(input int i, input logic [31:0] addr, input logic [7:0] len);
      req_awpld[i*45 +: 45] = aw_word(addr, len);
   endtask

   task automatic set_w(input int i, input logic [63:0] d, input logic [7:0] s, input logic l);
      req_wpld[i*73 +: 73] = {d, s, l};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL reset_grant got %b want 0000", grant);
      end
      checks++;
      if ({axi_awvalid, axi_wvalid, axi_bready, err_wlast} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 0000", {axi_awvalid, axi_wvalid, axi_bready, err_wlast});
      end
      checks++;
      if ({req_awready, req_wready, req_bvalid} !== 12'h000) begin
         errors++;
         $display("FAIL reset_req got %h want 000", {req_awready, req_wready, req_bvalid});
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_aw(1, 32'h0000_1000, 8'd3);
      req_awvalid = 4'b0010;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle_grant got %b want 0000", grant);
      end
      tick();
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0010 || axi_awvalid !== 1'b1) begin
         errors++;
         $display("FAIL single_grant got %b/%b want 0010/1", grant, axi_awvalid);
      end
      checks++;
      if (axi_awpld !== aw_word(32'h0000_1000, 8'd3) || req_awready !== 4'b0000) begin
         errors++;
         $display("FAIL single_aw got %h/%b want %h/0000", axi_awpld, req_awready,
                  aw_word(32'h0000_1000, 8'd3));
      end
      tick();
      @(negedge axi_aclk);
      checks++;
      if (axi_awvalid !== 1'b1 || axi_awpld !== aw_word(32'h0000_1000, 8'd3)) begin
         errors++;
         $display("FAIL single_aw_hold got %b/%h want 1/%h", axi_awvalid, axi_awpld,
                  aw_word(32'h0000_1000, 8'd3));
      end
      tick();
      axi_awready = 1'b1;
      @(negedge axi_aclk);
      checks++;
      if (req_awready !== 4'b0010) begin
         errors++;
         $display("FAIL single_awready got %b want 0010", req_awready);
      end
      tick();
      axi_awready = 1'b0;
      req_awvalid = 4'b0000;
      axi_wready  = 1'b1;
      req_wvalid  = 4'b0010;
      for (int b = 0; b < 4; b++) begin
         set_w(1, 64'hA0 + 64'(b), 8'hFF, b == 3);
         @(negedge axi_aclk);
         checks++;
         if (axi_wvalid !== 1'b1 || req_wready !== 4'b0010 ||
             axi_wpld !== {64'hA0 + 64'(b), 8'hFF, b == 3}) begin
            errors++;
            $display("FAIL single_wbeat%0d got %b/%b/%h want 1/0010/%h", b, axi_wvalid,
                     req_wready, axi_wpld, {64'hA0 + 64'(b), 8'hFF, b == 3});
         end
         tick();
      end
      req_wvalid = 4'b0000;
      axi_wready = 1'b0;
      axi_bvalid = 1'b1;
      axi_bresp  = 2'b10;
      req_bready = 4'b0010;
      @(negedge axi_aclk);
      checks++;
      if (req_bvalid !== 4'b0010 || req_bresp !== 2'b10 || axi_bready !== 1'b1) begin
         errors++;
         $display("FAIL single_b got %b/%b/%b want 0010/10/1", req_bvalid, req_bresp, axi_bready);
      end
      tick();
      axi_bvalid = 1'b0;
      req_bready = 4'b0000;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000 || req_bvalid !== 4'b0000 || axi_awvalid !== 1'b0 ||
          err_wlast !== 1'b0) begin
         errors++;
         $display("FAIL single_done got %b/%b/%b/%b want 0000/0000/0/0", grant, req_bvalid,
                  axi_awvalid, err_wlast);
      end
   endtask

   task automatic test_wlast_err();
      set_aw(2, 32'h0000_2000, 8'd1);
      req_awvalid = 4'b0100;
      tick();
      axi_awready = 1'b1;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("FAIL werr_grant got %b want 0100", grant);
      end
      tick();
      req_awvalid = 4'b0000;
      axi_awready = 1'b0;
      axi_wready  = 1'b1;
      req_wvalid  = 4'b0100;
      set_w(2, 64'hB0, 8'h0F, 1'b1);
      @(negedge axi_aclk);
      checks++;
      if (axi_wpld !== {64'hB0, 8'h0F, 1'b0}) begin
         errors++;
         $display("FAIL werr_beat0 got %h want %h", axi_wpld, {64'hB0, 8'h0F, 1'b0});
      end
      tick();
      set_w(2, 64'hB1, 8'h0F, 1'b1);
      @(negedge axi_aclk);
      checks++;
      if (err_wlast !== 1'b1) begin
         errors++;
         $display("FAIL werr_flag got %b want 1", err_wlast);
      end
      checks++;
      if (axi_wvalid !== 1'b1 || req_wready !== 4'b0100 || axi_wpld[0] !== 1'b1) begin
         errors++;
         $display("FAIL werr_beat1 got %b/%b/%b want 1/0100/1", axi_wvalid, req_wready,
                  axi_wpld[0]);
      end
      tick();
      req_wvalid = 4'b0000;
      axi_wready = 1'b0;
      axi_bvalid = 1'b1;
      req_bready = 4'b0100;
      @(negedge axi_aclk);
      checks++;
      if (req_bvalid !== 4'b0100) begin
         errors++;
         $display("FAIL werr_b got %b want 0100", req_bvalid);
      end
      tick();
      axi_bvalid = 1'b0;
      req_bready = 4'b0000;
      @(negedge axi_aclk);
      checks++;
      if (err_wlast !== 1'b1 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL werr_sticky got %b/%b want 1/0000", err_wlast, grant);
      end
   endtask

   task automatic test_reset_mid();
      // Pointer sits at 3 here, so requester 1 wins and the pointer moves to 2.
      set_aw(1, 32'h0000_3000, 8'd3);
      req_awvalid = 4'b0010;
      tick();
      axi_awready = 1'b1;
      tick();
      req_awvalid = 4'b0000;
      axi_awready = 1'b0;
      axi_wready  = 1'b1;
      req_wvalid  = 4'b0010;
      set_w(1, 64'hD0, 8'hFF, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000 || axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 ||
          req_wready !== 4'b0000 || err_wlast !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_outs got %b/%b/%b/%b/%b want 0000/0/0/0000/0", grant, axi_awvalid,
                  axi_wvalid, req_wready, err_wlast);
      end
      rst = 1'b0;
      clear_inputs();
      axi_bvalid = 1'b1;
      req_bready = 4'b1111;
      for (int i = 0; i < 4; i++) set_aw(i, 32'h0000_6000, 8'd0);
      req_awvalid = 4'b1111;
      @(negedge axi_aclk);
      checks++;
      if (req_bvalid !== 4'b0000 || axi_bready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_resp got %b/%b want 0000/0", req_bvalid, axi_bready);
      end
      tick();
      axi_bvalid = 1'b0;
      req_bready = 4'b0000;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_regrant got %b want 0001", grant);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp;
      logic [31:0] addr;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         addr = 32'(i) << 8;
         set_aw(i, addr, 8'd0);
         set_w(i, 64'hE0 + 64'(i), 8'hFF, 1'b1);
      end
      req_awvalid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         exp  = 4'b0001 << (t % 4);
         addr = 32'(t % 4) << 8;
         @(negedge axi_aclk);
         checks++;
         if (axi_awvalid !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL rr_idle%0d got %b/%b want 0/0000", t, axi_awvalid, grant);
         end
         tick();
         axi_awready = 1'b1;
         @(negedge axi_aclk);
         checks++;
         if (grant !== exp || axi_awvalid !== 1'b1 || axi_awpld !== aw_word(addr, 8'd0)) begin
            errors++;
            $display("FAIL rr_grant%0d got %b/%b/%h want %b/1/%h", t, grant, axi_awvalid,
                     axi_awpld, exp, aw_word(addr, 8'd0));
         end
         tick();
         axi_awready = 1'b0;
         req_wvalid  = 4'b1111;
         axi_wready  = 1'b1;
         @(negedge axi_aclk);
         checks++;
         if (req_wready !== exp) begin
            errors++;
            $display("FAIL rr_wready%0d got %b want %b", t, req_wready, exp);
         end
         tick();
         req_wvalid = 4'b0000;
         axi_wready = 1'b0;
         axi_bvalid = 1'b1;
         req_bready = 4'b1111;
         @(negedge axi_aclk);
         checks++;
         if (req_bvalid !== exp) begin
            errors++;
            $display("FAIL rr_bvalid%0d got %b want %b", t, req_bvalid, exp);
         end
         tick();
         axi_bvalid = 1'b0;
         req_bready = 4'b0000;
      end
      req_awvalid = 4'b0000;
   endtask

   task automatic test_withdraw();
      // Last winner was 0; with only requester 0 asking it still wins.
      tick();
      set_aw(0, 32'h0000_4000, 8'd0);
      req_awvalid = 4'b0001;
      tick();
      axi_awready = 1'b1;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL wd_grant got %b want 0001", grant);
      end
      tick();
      axi_awready = 1'b0;
      req_awvalid = 4'b1000;
      set_w(0, 64'hF0, 8'hFF, 1'b1);
      req_wvalid = 4'b0001;
      axi_wready = 1'b1;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0001 || req_awready !== 4'b0000) begin
         errors++;
         $display("FAIL wd_wait got %b/%b want 0001/0000", grant, req_awready);
      end
      tick();
      req_wvalid = 4'b0000;
      axi_wready = 1'b0;
      axi_bvalid = 1'b1;
      req_bready = 4'b0001;
      @(negedge axi_aclk);
      checks++;
      if (req_bvalid !== 4'b0001) begin
         errors++;
         $display("FAIL wd_b got %b want 0001", req_bvalid);
      end
      tick();
      req_awvalid = 4'b0000;
      axi_bvalid  = 1'b0;
      req_bready  = 4'b0000;
      tick();
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000 || axi_awvalid !== 1'b0) begin
         errors++;
         $display("FAIL wd_ignored got %b/%b want 0000/0", grant, axi_awvalid);
      end
      tick();
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000 || axi_awvalid !== 1'b0) begin
         errors++;
         $display("FAIL wd_ignored2 got %b/%b want 0000/0", grant, axi_awvalid);
      end
   endtask

`ifdef AXI_WR_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      set_aw(0, 32'h0000_5000, 8'd3);
      req_awvalid = 4'b0001;
      tick();
      axi_awready = 1'b1;
      tick();
      axi_awready = 1'b0;
      req_awvalid = 4'b0000;
      axi_wready  = 1'b1;
      set_w(0, 64'hC0, 8'hFF, 1'b0);
      req_wvalid = 4'b0001;
      tick();
      req_wvalid = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         @(negedge axi_aclk);
         checks++;
         if (axi_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait%0d got %b want 0", k, axi_wvalid);
         end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge axi_aclk);
         checks++;
         if (axi_wvalid !== 1'b1 || axi_wpld[8:1] !== 8'h00 || axi_wpld[0] !== (k == 2) ||
             req_wready !== 4'b0000) begin
            errors++;
            $display("FAIL tmo_beat%0d got %b/%h/%b/%b want 1/00/%b/0000", k, axi_wvalid,
                     axi_wpld[8:1], axi_wpld[0], req_wready, k == 2);
         end
         tick();
      end
      axi_wready = 1'b0;
      axi_bvalid = 1'b1;
      req_bready = 4'b0001;
      @(negedge axi_aclk);
      checks++;
      if (err_wlast !== 1'b1 || req_bvalid !== 4'b0001) begin
         errors++;
         $display("FAIL tmo_b got %b/%b want 1/0001", err_wlast, req_bvalid);
      end
      tick();
      axi_bvalid = 1'b0;
      req_bready = 4'b0000;
      @(negedge axi_aclk);
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL tmo_done got %b want 0000", grant);
      end
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_wlast_err();
      test_reset_mid();
      test_round_robin();
      test_withdraw();
`ifdef AXI_WR_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
